// File: rtl/simple_decoder.sv
// simple_decoder: receive-side decoder for the {data[7:0], data[3:0]} check-nibble
// codeword. It flags mismatches between the check nibble and the data low nibble,
// buffers decoded words in a 2-entry elastic buffer, and keeps saturating
// word/error counters for link-status monitoring.
module simple_decoder #(
  parameter int CNT_W         = 16,
  parameter bit DROP_ON_ERROR = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [11:0]      in_codeword,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [7:0]       out_data,
  output logic             out_err,
  output logic [3:0]       out_syndrome,
  input  logic             clr_counts,
  output logic [CNT_W-1:0] word_count,
  output logic [CNT_W-1:0] err_count
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } occ_e;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  occ_e state_q, state_d;

  // Entries are {data[7:0], err, syndrome[3:0]}; head_q is what the output shows.
  logic [12:0] head_q, head_d;
  logic [12:0] tail_q, tail_d;
  logic [CNT_W-1:0] word_count_q, word_count_d;
  logic [CNT_W-1:0] err_count_q, err_count_d;

  logic [3:0]  syn;
  logic        err;
  logic [12:0] newEntry;
  logic        accept;
  logic        pop;
  logic        write;

  // Combinational decode of the incoming codeword; in drop mode only clean words
  // are ever stored, so the stored error/syndrome fields are forced to zero.
  always_comb begin
    syn      = in_codeword[3:0] ^ in_codeword[7:4];
    err      = |syn;
    newEntry = {in_codeword[11:4], (DROP_ON_ERROR ? 5'd0 : {err, syn})};
  end

  assign accept = in_valid && in_ready;
  assign pop    = out_valid && out_ready;
  assign write  = accept && !(DROP_ON_ERROR && err);

  // State register together with buffer storage and counters; reset clears everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= EMPTY;
      head_q       <= '0;
      tail_q       <= '0;
      word_count_q <= '0;
      err_count_q  <= '0;
    end else begin
      state_q      <= state_d;
      head_q       <= head_d;
      tail_q       <= tail_d;
      word_count_q <= word_count_d;
      err_count_q  <= err_count_d;
    end
  end

  // Next occupancy state and buffer contents; a word dropped in drop mode does not advance state.
  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    tail_d  = tail_q;
    unique case (state_q)
      EMPTY: begin
        if (write) begin
          head_d  = newEntry;
          state_d = ONE;
        end
      end
      ONE: begin
        if (write && pop) begin
          head_d = newEntry;
        end else if (write) begin
          tail_d  = newEntry;
          state_d = FULL;
        end else if (pop) begin
          state_d = EMPTY;
        end
      end
      FULL: begin
        if (pop) begin
          head_d  = tail_q;
          state_d = ONE;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  // Saturating counters; a clear on the same edge as an accept wins.
  always_comb begin
    word_count_d = word_count_q;
    err_count_d  = err_count_q;
    if (clr_counts) begin
      word_count_d = '0;
      err_count_d  = '0;
    end else if (accept) begin
      if (word_count_q != CNT_MAX) begin
        word_count_d = word_count_q + CNT_ONE;
      end
      if (err && (err_count_q != CNT_MAX)) begin
        err_count_d = err_count_q + CNT_ONE;
      end
    end
  end

  // Outputs: handshake flags from registered state only, data fields from the head entry.
  always_comb begin
    in_ready     = (state_q != FULL) && !rst;
    out_valid    = (state_q != EMPTY);
    out_data     = head_q[12:5];
    out_err      = head_q[4];
    out_syndrome = head_q[3:0];
    word_count   = word_count_q;
    err_count    = err_count_q;
  end

endmodule

// File: tb/tb_simple_decoder.sv
// Self-checking bench for simple_decoder. Two instances share one input stream:
// instance A forwards errored words with 4-bit counters, instance B drops errored
// words with 16-bit counters. A list-based reference model predicts both.
module tb_simple_decoder;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [11:0] in_codeword;
  logic        out_ready;
  logic        clr_counts;

  logic        inReadyA, outValidA, outErrA;
  logic [7:0]  outDataA;
  logic [3:0]  outSynA;
  logic [3:0]  wordCountA, errCountA;

  logic        inReadyB, outValidB, outErrB;
  logic [7:0]  outDataB;
  logic [3:0]  outSynB;
  logic [15:0] wordCountB, errCountB;

  int errors = 0;
  int checks = 0;

  // Reference model: per instance an ordered list of pending entries and two counts.
  logic [12:0] mBuf [2][2];
  int          mSize [2] = '{0, 0};
  longint      mWord [2] = '{0, 0};
  longint      mErr  [2] = '{0, 0};
  longint      mMax  [2] = '{15, 65535};

  logic [7:0] popA[$];
  logic [7:0] popB[$];

  simple_decoder #(.CNT_W(4), .DROP_ON_ERROR(1'b0)) dutA (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(inReadyA),
    .in_codeword(in_codeword), .out_valid(outValidA), .out_ready(out_ready),
    .out_data(outDataA), .out_err(outErrA), .out_syndrome(outSynA),
    .clr_counts(clr_counts), .word_count(wordCountA), .err_count(errCountA)
  );

  simple_decoder #(.CNT_W(16), .DROP_ON_ERROR(1'b1)) dutB (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(inReadyB),
    .in_codeword(in_codeword), .out_valid(outValidB), .out_ready(out_ready),
    .out_data(outDataB), .out_err(outErrB), .out_syndrome(outSynB),
    .clr_counts(clr_counts), .word_count(wordCountB), .err_count(errCountB)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic r, input logic v, input logic [11:0] cw,
                               input logic ordy, input logic clr);
    #1;
    rst         = r;
    in_valid    = v;
    in_codeword = cw;
    out_ready   = ordy;
    clr_counts  = clr;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic compareDut(input int d, input logic ir, input logic ov, input logic [7:0] od,
                            input logic oe, input logic [3:0] os,
                            input logic [31:0] wc, input logic [31:0] ec);
    string p;
    p = (d == 0) ? "A" : "B";
    checkOutput({p, "_in_ready"}, 32'(ir), 32'(!rst && (mSize[d] < 2)));
    checkOutput({p, "_out_valid"}, 32'(ov), 32'(mSize[d] > 0));
    if (mSize[d] > 0) begin
      checkOutput({p, "_out_data"}, 32'(od), 32'(mBuf[d][0][12:5]));
      checkOutput({p, "_out_err"}, 32'(oe), 32'(mBuf[d][0][4]));
      checkOutput({p, "_out_syndrome"}, 32'(os), 32'(mBuf[d][0][3:0]));
    end
    checkOutput({p, "_word_count"}, wc, 32'(mWord[d]));
    checkOutput({p, "_err_count"}, ec, 32'(mErr[d]));
  endtask

  // Model update at each rising edge from the inputs presented before the edge.
  always @(posedge clk) begin : model
    logic [3:0] syn;
    logic       e, rdy, acc, pp;
    for (int d = 0; d < 2; d++) begin
      syn = in_codeword[3:0] ^ in_codeword[7:4];
      e   = (syn != 4'd0);
      rdy = !rst && (mSize[d] < 2);
      acc = in_valid && rdy;
      pp  = (mSize[d] > 0) && out_ready;
      if (rst) begin
        mSize[d] = 0;
        mWord[d] = 0;
        mErr[d]  = 0;
      end else begin
        if (pp) begin
          mBuf[d][0] = mBuf[d][1];
          mSize[d]   = mSize[d] - 1;
        end
        if (acc && !(d == 1 && e)) begin
          mBuf[d][mSize[d]] = (d == 1) ? {in_codeword[11:4], 5'd0}
                                       : {in_codeword[11:4], e, syn};
          mSize[d] = mSize[d] + 1;
        end
        if (clr_counts) begin
          mWord[d] = 0;
          mErr[d]  = 0;
        end else if (acc) begin
          if (mWord[d] < mMax[d]) mWord[d] = mWord[d] + 1;
          if (e && (mErr[d] < mMax[d])) mErr[d] = mErr[d] + 1;
        end
      end
    end
  end

  // Record every word actually handed downstream.
  always @(posedge clk) begin
    if (!rst && outValidA && out_ready) popA.push_back(outDataA);
    if (!rst && outValidB && out_ready) popB.push_back(outDataB);
  end

  // Compare both instances against the model every cycle.
  always @(negedge clk) begin
    compareDut(0, inReadyA, outValidA, outDataA, outErrA, outSynA, 32'(wordCountA), 32'(errCountA));
    compareDut(1, inReadyB, outValidB, outDataB, outErrB, outSynB, 32'(wordCountB), 32'(errCountB));
  end

  initial begin
    logic [7:0] dat;
    rst = 1'b1; in_valid = 1'b0; in_codeword = '0; out_ready = 1'b0; clr_counts = 1'b0;
    @(negedge clk);
    applyStimulus(1, 0, 12'h000, 0, 0);

    $display("[TB] reset state");
    checkOutput("rst_out_valid", 32'(outValidA), 32'd0);
    checkOutput("rst_in_ready", 32'(inReadyA), 32'd0);
    checkOutput("rst_out_data", 32'(outDataA), 32'd0);
    checkOutput("rst_word_count", 32'(wordCountA), 32'd0);
    checkOutput("rst_err_count", 32'(errCountA), 32'd0);

    $display("[TB] clean word");
    applyStimulus(0, 0, 12'h000, 1, 0);
    applyStimulus(0, 1, 12'hAAA, 1, 0);
    checkOutput("clean_out_data", 32'(outDataA), 32'hAA);
    checkOutput("clean_out_err", 32'(outErrA), 32'd0);
    checkOutput("clean_syndrome", 32'(outSynA), 32'h0);
    checkOutput("clean_word_count", 32'(wordCountA), 32'd1);
    checkOutput("clean_err_count", 32'(errCountA), 32'd0);
    checkOutput("model_word_after_first", 32'(mWord[0]), 32'd1);

    $display("[TB] errored words");
    applyStimulus(0, 1, 12'hAA5, 1, 0);
    checkOutput("err1_out_data", 32'(outDataA), 32'hAA);
    checkOutput("err1_out_err", 32'(outErrA), 32'd1);
    checkOutput("err1_syndrome", 32'(outSynA), 32'hF);
    checkOutput("err1_err_count", 32'(errCountA), 32'd1);
    checkOutput("model_err1_entry", 32'(mBuf[0][0]), 32'({8'hAA, 1'b1, 4'hF}));
    applyStimulus(0, 1, 12'h3C4, 1, 0);
    checkOutput("err2_syndrome", 32'(outSynA), 32'h8);
    checkOutput("err2_err_count", 32'(errCountA), 32'd2);
    checkOutput("drop_B_word_count", 32'(wordCountB), 32'd3);
    checkOutput("drop_B_err_count", 32'(errCountB), 32'd2);
    applyStimulus(0, 0, 12'h000, 1, 0);

    $display("[TB] backpressure");
    popA.delete();
    applyStimulus(0, 1, 12'h111, 0, 0);
    applyStimulus(0, 1, 12'h222, 0, 0);
    applyStimulus(0, 1, 12'h333, 0, 0);
    checkOutput("bp_in_ready_full", 32'(inReadyA), 32'd0);
    checkOutput("bp_held_head", 32'(outDataA), 32'h11);
    checkOutput("bp_word_count", 32'(wordCountA), 32'd5);
    applyStimulus(0, 1, 12'h333, 1, 0);
    applyStimulus(0, 1, 12'h333, 1, 0);
    applyStimulus(0, 0, 12'h000, 1, 0);
    applyStimulus(0, 0, 12'h000, 1, 0);
    checkOutput("bp_pop_count", 32'(popA.size()), 32'd3);
    if (popA.size() == 3) begin
      checkOutput("bp_pop0", 32'(popA[0]), 32'h11);
      checkOutput("bp_pop1", 32'(popA[1]), 32'h22);
      checkOutput("bp_pop2", 32'(popA[2]), 32'h33);
    end

    $display("[TB] drop mode");
    applyStimulus(0, 0, 12'h000, 1, 1);
    popA.delete();
    popB.delete();
    applyStimulus(0, 1, 12'h555, 1, 0);
    applyStimulus(0, 1, 12'h556, 1, 0);
    applyStimulus(0, 1, 12'h777, 1, 0);
    applyStimulus(0, 0, 12'h000, 1, 0);
    applyStimulus(0, 0, 12'h000, 1, 0);
    checkOutput("drop_pop_count", 32'(popB.size()), 32'd2);
    if (popB.size() == 2) begin
      checkOutput("drop_pop0", 32'(popB[0]), 32'h55);
      checkOutput("drop_pop1", 32'(popB[1]), 32'h77);
    end
    checkOutput("drop_word_count", 32'(wordCountB), 32'd3);
    checkOutput("drop_err_count", 32'(errCountB), 32'd1);
    checkOutput("fwd_pop_count", 32'(popA.size()), 32'd3);

    $display("[TB] saturation and clear");
    applyStimulus(0, 0, 12'h000, 1, 1);
    for (int i = 0; i < 17; i++) applyStimulus(0, 1, 12'hAA5, 1, 0);
    checkOutput("sat_word_count", 32'(wordCountA), 32'd15);
    checkOutput("sat_err_count", 32'(errCountA), 32'd15);
    checkOutput("nosat_B_word_count", 32'(wordCountB), 32'd17);
    applyStimulus(0, 1, 12'hAAA, 1, 1);
    checkOutput("clr_word_count", 32'(wordCountA), 32'd0);
    checkOutput("clr_err_count", 32'(errCountA), 32'd0);
    applyStimulus(0, 0, 12'h000, 1, 0);

    $display("[TB] reset mid-stream");
    applyStimulus(0, 1, 12'h111, 0, 0);
    applyStimulus(0, 1, 12'h222, 0, 0);
    checkOutput("full_in_ready", 32'(inReadyA), 32'd0);
    applyStimulus(1, 0, 12'h000, 0, 0);
    checkOutput("midrst_out_valid", 32'(outValidA), 32'd0);
    checkOutput("midrst_in_ready", 32'(inReadyA), 32'd0);
    checkOutput("midrst_out_data", 32'(outDataA), 32'd0);
    applyStimulus(0, 1, 12'h999, 1, 0);
    checkOutput("postrst_out_data", 32'(outDataA), 32'h99);
    checkOutput("postrst_word_count", 32'(wordCountA), 32'd1);

    $display("[TB] random traffic");
    for (int i = 0; i < 3000; i++) begin
      dat = 8'($urandom);
      applyStimulus(($urandom_range(0, 99) == 0),
                    ($urandom_range(0, 3) != 0),
                    ($urandom_range(0, 1) == 1) ? {dat, dat[3:0]} : 12'($urandom),
                    ($urandom_range(0, 2) != 0),
                    ($urandom_range(0, 49) == 0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
